// File: rtl/pwm_capture_module.sv
// PWM receive-side capture: measures high time and period of pwm_in and
// reports duty on a 0-255 scale via an 8-step restoring divider.
module pwm_capture_module #(
  parameter int unsigned      CNT_W   = 20,
  parameter logic [CNT_W-1:0] TIMEOUT = 20'd1000000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period,
  output logic             stuck
);

  localparam logic [1:0] M_WAIT = 2'd0;
  localparam logic [1:0] M_HIGH = 2'd1;
  localparam logic [1:0] M_LOW  = 2'd2;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_RUN  = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;

  logic             r_sync1, r_sync2, r_sync_d;
  logic             w_rise, w_fall;
  logic [1:0]       r_mstate, r_dstate;
  logic [CNT_W-1:0] r_high_cnt, r_per_cnt;
  logic [CNT_W-1:0] w_per_inc;
  logic             w_tmo_hit, w_meas_tmo, w_wait_tmo, w_tmo_report, w_handoff;
  logic [CNT_W-1:0] r_rem, r_div;
  logic [6:0]       r_quo;
  logic [2:0]       r_iter;
  logic [CNT_W:0]   w_shift;
  logic [CNT_W-1:0] w_sub;
  logic             w_ge;
  logic [7:0]       w_qnext;
  logic             w_div_last;
  logic [7:0]       r_duty;
  logic [CNT_W-1:0] r_period;
  logic             r_valid, r_stuck;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= pwm_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;
  assign w_fall = ~r_sync2 & r_sync_d;

  assign w_tmo_hit    = (r_per_cnt == TIMEOUT);
  assign w_per_inc    = w_tmo_hit ? r_per_cnt : r_per_cnt + CNT_W'(1);
  assign w_meas_tmo   = w_tmo_hit && !w_rise && (r_mstate != M_WAIT);
  assign w_wait_tmo   = w_tmo_hit && !w_rise && (r_mstate == M_WAIT) && !r_stuck;
  assign w_tmo_report = w_meas_tmo | w_wait_tmo;
  assign w_handoff    = w_rise && (r_mstate == M_LOW) && (r_dstate == D_IDLE);

  // Counters load 1 on a rise so the rise cycle itself is counted:
  // a clean H-high/L-low input then yields high=H, period=H+L at the next edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_mstate   <= M_WAIT;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
    end else if (w_rise && (r_mstate != M_HIGH)) begin
      r_mstate   <= M_HIGH;
      r_high_cnt <= CNT_W'(1);
      r_per_cnt  <= CNT_W'(1);
    end else if (w_meas_tmo) begin
      r_mstate <= M_WAIT;
    end else begin
      r_per_cnt <= w_per_inc;
      if (r_mstate == M_HIGH) begin
        if (w_fall) r_mstate <= M_LOW;
        else        r_high_cnt <= r_high_cnt + CNT_W'(1);
      end
    end
  end

  // Remainder stays below the divisor, so the subtraction fits in CNT_W bits.
  assign w_shift    = {r_rem, 1'b0};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_sub      = w_shift[CNT_W-1:0] - r_div;
  assign w_qnext    = {r_quo, w_ge};
  assign w_div_last = (r_dstate == D_RUN) && (r_iter == 3'd7);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dstate <= D_IDLE;
      r_rem    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_iter   <= '0;
    end else begin
      case (r_dstate)
        D_IDLE: if (w_handoff) begin
          r_rem    <= r_high_cnt;
          r_div    <= r_per_cnt;
          r_quo    <= '0;
          r_iter   <= '0;
          r_dstate <= D_RUN;
        end
        D_RUN: begin
          r_rem  <= w_ge ? w_sub : w_shift[CNT_W-1:0];
          r_quo  <= w_qnext[6:0];
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_dstate <= D_DONE;
        end
        D_DONE:  r_dstate <= D_IDLE;
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  // Results are written on the last iteration edge so they are visible
  // (with duty_valid) during the single D_DONE cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_duty   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tmo_report) begin
        r_stuck  <= 1'b1;
        r_duty   <= r_sync2 ? 8'hFF : 8'h00;
        r_period <= '0;
        r_valid  <= 1'b1;
      end else if (w_div_last) begin
        r_duty   <= w_qnext;
        r_period <= r_div;
        r_valid  <= 1'b1;
      end
      if (w_rise) r_stuck <= 1'b0;
    end
  end

  assign duty       = r_duty;
  assign duty_valid = r_valid;
  assign period     = r_period;
  assign stuck      = r_stuck;

endmodule

// File: tb/tb_pwm_capture_module.sv
// Bench for pwm_capture_module: table-driven clean PWM vectors plus timeout,
// overrun and reset sequences, with a queue scoreboard popped on duty_valid.
module tb_pwm_capture_module;

  localparam int unsigned CNT_W = 20;
  localparam int unsigned TMO   = 6000;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             pwm_in = 1'b0;
  logic [7:0]       duty;
  logic             duty_valid;
  logic [CNT_W-1:0] period;
  logic             stuck;

  always #5 CLK = ~CLK;

  pwm_capture_module #(
    .CNT_W   (CNT_W),
    .TIMEOUT (20'd6000)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .period     (period),
    .stuck      (stuck)
  );

  typedef struct {
    logic [7:0]       duty;
    logic [CNT_W-1:0] period;
    logic             stuck;
  } exp_t;

  typedef struct {
    int         h;
    int         l;
    logic [7:0] duty;
    int         period;
  } vec_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     free_mode = 1'b0;
  int     free_reports = 0;
  longint cyc = 0;
  longint last_valid_cyc = 0;

  always @(posedge CLK) cyc++;

  function automatic exp_t mk(input int d, input int p, input bit s);
    exp_t e;
    e.duty   = 8'(d);
    e.period = CNT_W'(p);
    e.stuck  = s;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (RSTn && duty_valid) begin
      if (free_mode) begin
        check("free no X", longint'($isunknown({duty, period, stuck})), 0);
        check("free duty", duty, 128);
        check("free period", period, 4);
        if (free_reports > 0)
          check("free spacing>=10", longint'((cyc - last_valid_cyc) >= 10), 1);
        free_reports++;
        last_valid_cyc = cyc;
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected duty_valid: got duty=%0d period=%0d stuck=%0d, expected no report",
                 duty, period, stuck);
      end else begin
        mon_e = sb.pop_front();
        check("report duty", duty, mon_e.duty);
        check("report period", period, mon_e.period);
        check("report stuck", stuck, mon_e.stuck);
      end
    end
  end

  task automatic do_reset();
    RSTn = 1'b0;
    pwm_in = 1'b0;
    tick(2);
    sb.delete();
    RSTn = 1'b1;
    tick(5);
  endtask

  // One PWM period starting with a rise; push = a report of the previous period is due.
  task automatic drive_period(input int h, input int l, input bit push, input exp_t e);
    pwm_in = 1'b1;
    if (push) sb.push_back(e);
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    while (!dut.w_rise && k < 10) begin
      tick(1);
      k++;
    end
    check("rise detected", dut.w_rise, 1);
  endtask

  vec_t vt[7];
  exp_t none;

  initial begin
    int kr, kl;
    none = mk(0, 0, 0);
    vt[0] = '{98, 98, 8'd128, 196};
    vt[1] = '{1, 255, 8'd1, 256};
    vt[2] = '{255, 1, 8'd255, 256};
    vt[3] = '{1911, 3089, 8'd97, 5000};
    vt[4] = '{3, 7, 8'd76, 10};
    vt[5] = '{37, 63, 8'd94, 100};
    vt[6] = '{200, 56, 8'd200, 256};

    RSTn = 1'b0;
    tick(2);
    check("reset duty", duty, 0);
    check("reset duty_valid", duty_valid, 0);
    check("reset period", period, 0);
    check("reset stuck", stuck, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int r = 0; r < 3; r++)
        drive_period(vt[i].h, vt[i].l, r > 0, mk(vt[i].duty, vt[i].period, 1'b0));
      tick(30);
      check("table queue drained", sb.size(), 0);
    end

    // Report latency from rise detection, then input stuck high.
    do_reset();
    drive_period(98, 98, 1'b0, none);
    pwm_in = 1'b1;
    sb.push_back(mk(128, 196, 1'b0));
    wait_rise(kr);
    kl = 0;
    while (!duty_valid && kl < 20) begin
      tick(1);
      kl++;
    end
    check("valid latency after rise", kl, 9);
    tick(98 - kr - kl);
    pwm_in = 1'b0;
    tick(98);
    sb.push_back(mk(128, 196, 1'b0));
    sb.push_back(mk(255, 0, 1'b1));
    pwm_in = 1'b1;
    tick(TMO + 100);
    check("stuck high flag", stuck, 1);
    check("stuck high duty", duty, 255);
    check("stuck high period", period, 0);
    check("stuck high queue drained", sb.size(), 0);
    pwm_in = 1'b0;
    tick(98);
    check("stuck held while low", stuck, 1);
    pwm_in = 1'b1;
    tick(5);
    check("stuck clears on rise", stuck, 0);
    tick(93);
    pwm_in = 1'b0;
    tick(98);
    drive_period(98, 98, 1'b1, mk(128, 196, 1'b0));
    tick(30);
    check("resume queue drained", sb.size(), 0);

    // Held low from reset: single timeout report at TIMEOUT+1 cycles.
    RSTn = 1'b0;
    pwm_in = 1'b0;
    tick(2);
    sb.delete();
    sb.push_back(mk(0, 0, 1'b1));
    RSTn = 1'b1;
    kl = 0;
    while (!duty_valid && kl < int'(TMO) + 20) begin
      tick(1);
      kl++;
    end
    check("wait timeout latency", kl, TMO + 1);
    tick(TMO + 100);
    check("low timeout stuck", stuck, 1);
    check("low timeout duty", duty, 0);
    check("low timeout queue drained", sb.size(), 0);

    // Fast input: divider overruns, only idle handoffs report.
    do_reset();
    free_mode = 1'b1;
    free_reports = 0;
    for (int r = 0; r < 200; r++) drive_period(2, 2, 1'b0, none);
    tick(20);
    free_mode = 1'b0;
    check("fast reports at most every 10", longint'(free_reports >= 50 && free_reports <= 80), 1);

    // Reset asserted while the divider is running.
    do_reset();
    drive_period(98, 98, 1'b0, none);
    drive_period(98, 98, 1'b1, mk(128, 196, 1'b0));
    check("pre-reset duty", duty, 128);
    pwm_in = 1'b1;
    wait_rise(kr);
    tick(3);
    check("divider running", dut.r_dstate, 1);
    RSTn = 1'b0;
    #1;
    check("async reset duty", duty, 0);
    check("async reset period", period, 0);
    check("async reset valid", duty_valid, 0);
    check("async reset stuck", stuck, 0);
    pwm_in = 1'b0;
    tick(2);
    sb.delete();
    RSTn = 1'b1;
    tick(5);
    drive_period(98, 98, 1'b0, none);
    drive_period(98, 98, 1'b1, mk(128, 196, 1'b0));
    tick(30);
    check("post-reset queue drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
